// File: rtl/pcpu_pkg.sv
// rtl/pcpu_pkg.sv - shared CPU bus types: arbiter state encoding, widths, requester IDs
package pcpu_pkg;

  localparam int PCPU_ADDR_W = 16;
  localparam int PCPU_DATA_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUS_IF = 2'd1,
    ARB_BUS_D  = 2'd2,
    ARB_RESP   = 2'd3
  } arb_state_e;

  localparam logic REQ_ID_IF = 1'b0;
  localparam logic REQ_ID_D  = 1'b1;

  function automatic arb_state_e bus_state_for(input logic req_id);
    return (req_id == REQ_ID_D) ? ARB_BUS_D : ARB_BUS_IF;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// rtl/bus_watchdog.sv - 8-bit bus-cycle counter that flags an access exceeding its timeout
module bus_watchdog (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] timeout_i,
  output logic       expire_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the last allowed cycle so the caller drops its request after exactly timeout_i cycles.
  assign expire_o = en_i && (timeout_i != 8'd0) && (cnt_q == (timeout_i - 8'd1));

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between fetch and load/store paths
module mem_arbiter
  import pcpu_pkg::*;
#(
  parameter int ADDR_W     = PCPU_ADDR_W,
  parameter int DATA_W     = PCPU_DATA_W,
  parameter int MAX_STARVE = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  localparam logic [3:0] MAX_STARVE_C = 4'(MAX_STARVE);
  localparam logic [7:0] TIMEOUT_C    = 8'(TIMEOUT);

  arb_state_e        state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              win_any;
  logic              win_id;
  logic              in_bus;
  logic              wd_expire;

  assign in_bus = (state_q == ARB_BUS_IF) || (state_q == ARB_BUS_D);

  bus_watchdog u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (!in_bus),
    .en_i      (in_bus),
    .timeout_i (TIMEOUT_C),
    .expire_o  (wd_expire)
  );

  // Data normally wins a tie; a fetch that has lost MAX_STARVE ties in a row takes the next one.
  always_comb begin
    win_any = if_req || d_req;
    win_id  = REQ_ID_D;
    if (if_req && (!d_req || (starve_q == MAX_STARVE_C))) begin
      win_id = REQ_ID_IF;
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (win_any) begin
          state_d   = bus_state_for(win_id);
          mem_req_d = 1'b1;
          if (win_id == REQ_ID_IF) begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            starve_d    = '0;
          end else begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            if (if_req && (starve_q != 4'hF)) begin
              starve_d = starve_q + 4'd1;
            end
          end
        end
      end

      ARB_BUS_IF, ARB_BUS_D: begin
        // A same-cycle ack beats the watchdog so completed data is never discarded.
        if (mem_ack || wd_expire) begin
          state_d   = ARB_RESP;
          mem_req_d = 1'b0;
          err_d     = !mem_ack;
          if (state_q == ARB_BUS_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ack ? mem_rdata : '0;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = mem_ack ? mem_rdata : '0;
          end
        end
      end

      ARB_RESP: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a scripted memory responder
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_ack;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        busy;

  mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .MAX_STARVE(3), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  typedef struct packed {
    logic        is_d;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] grant_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  int          mem_wait;
  bit          mem_never;
  logic [15:0] mem_key;
  int          bus_cyc;
  int          last_req_len;
  logic        cmd_we;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  bit          cmd_unstable;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic is_d, input logic [15:0] rdata, input logic e);
    exp_t x;
    x.is_d  = is_d;
    x.rdata = rdata;
    x.err   = e;
    exp_q.push_back(x);
  endtask

  task automatic wait_ack(input string name, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!(if_ack || d_ack) && (cyc < 100));
    if (!(if_ack || d_ack)) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no ack within %0d cycles", name, cyc);
    end
  endtask

  // Memory model: decides mem_ack on the falling edge so the arbiter samples it on the next rise.
  initial begin
    mem_ack      = 1'b0;
    mem_rdata    = 16'h0000;
    bus_cyc      = 0;
    last_req_len = 0;
    cmd_unstable = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        bus_cyc++;
        if (bus_cyc == 1) begin
          cmd_we       = mem_we;
          cmd_addr     = mem_addr;
          cmd_wdata    = mem_wdata;
          cmd_unstable = 1'b0;
          grant_q.push_back(mem_addr);
        end else if ({mem_we, mem_addr, mem_wdata} !== {cmd_we, cmd_addr, cmd_wdata}) begin
          cmd_unstable = 1'b1;
        end
        if (!mem_never && (bus_cyc == mem_wait + 1)) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_addr ^ mem_key;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 16'hDEAD;
        end
      end else begin
        if (bus_cyc != 0) last_req_len = bus_cyc;
        bus_cyc = 0;
        mem_ack = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (if_ack || d_ack) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ack: if_ack=%0b d_ack=%0b", if_ack, d_ack);
        end else begin
          e = exp_q.pop_front();
          check("ack_port", {30'd0, if_ack, d_ack}, e.is_d ? 32'd1 : 32'd2);
          check("ack_rdata", e.is_d ? {16'd0, d_rdata} : {16'd0, if_rdata}, {16'd0, e.rdata});
          check("ack_err", {31'd0, err}, {31'd0, e.err});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int          cyc;
    logic [15:0] exp_g [8];
    exp_g = '{16'h4000, 16'h4000, 16'h4000, 16'h0300,
              16'h4000, 16'h4000, 16'h4000, 16'h0300};

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_wait = 0; mem_never = 1'b0; mem_key = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_cmd", {13'd0, mem_req, mem_we, busy, mem_addr}, 32'd0);
    check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    check("rst_acks", {29'd0, if_ack, d_ack, err}, 32'd0);
    check("rst_rdata", {if_rdata, d_rdata}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fetch with zero-wait memory.
    mem_wait = 0; mem_key = 16'hBFEF;
    push_exp(1'b0, 16'hBEEF, 1'b0);
    if_addr = 16'h0100; if_req = 1'b1;
    wait_ack("t1_ack", cyc);
    if_req = 1'b0;
    check("t1_latency", cyc, 2);
    @(posedge clk); #1;
    check("t1_req_len", last_req_len, 1);
    check("t1_cmd", {15'd0, cmd_we, cmd_addr}, 32'h0000_0100);

    // Store with 4 wait cycles; requester inputs change mid-access.
    mem_wait = 4; mem_key = 16'h7A7A;
    push_exp(1'b1, 16'h5A7A, 1'b0);
    d_we = 1'b1; d_addr = 16'h2000; d_wdata = 16'h1234; d_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    d_addr = 16'hFFFF; d_wdata = 16'hFFFF; d_we = 1'b0;
    wait_ack("t2_ack", cyc);
    d_req = 1'b0;
    @(posedge clk); #1;
    check("t2_req_len", last_req_len, 5);
    check("t2_cmd", {15'd0, cmd_we, cmd_addr}, 32'h0001_2000);
    check("t2_wdata", {16'd0, cmd_wdata}, 32'h0000_1234);
    check("t2_stable", {31'd0, cmd_unstable}, 32'd0);

    // Both requesters held: starvation bound forces every fourth grant to fetch.
    mem_wait = 0; mem_key = 16'h1111;
    grant_q.delete();
    for (int i = 0; i < 8; i++) begin
      if (exp_g[i] == 16'h0300) push_exp(1'b0, 16'h1211, 1'b0);
      else                      push_exp(1'b1, 16'h5111, 1'b0);
    end
    d_we = 1'b0; d_addr = 16'h4000; if_addr = 16'h0300;
    d_req = 1'b1; if_req = 1'b1;
    for (int i = 0; i < 8; i++) wait_ack("t3_ack", cyc);
    d_req = 1'b0; if_req = 1'b0;
    @(posedge clk); #1;
    check("t3_grants", grant_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < grant_q.size()) check("t3_grant_order", {16'd0, grant_q[i]}, {16'd0, exp_g[i]});
    end

    // Load that never completes: watchdog aborts after exactly 8 cycles.
    mem_never = 1'b1;
    push_exp(1'b1, 16'h0000, 1'b1);
    d_addr = 16'h0040; d_req = 1'b1;
    wait_ack("t4_ack", cyc);
    d_req = 1'b0; mem_never = 1'b0;
    @(posedge clk); #1;
    check("t4_req_len", last_req_len, 8);

    mem_wait = 1;
    push_exp(1'b0, 16'h1311, 1'b0);
    if_addr = 16'h0200; if_req = 1'b1;
    wait_ack("t4b_ack", cyc);
    if_req = 1'b0;
    @(posedge clk); #1;
    check("t4b_req_len", last_req_len, 2);

    // Ack lands in the same cycle the watchdog expires.
    mem_wait = 7;
    push_exp(1'b1, 16'h1191, 1'b0);
    d_addr = 16'h0080; d_req = 1'b1;
    wait_ack("t5_ack", cyc);
    d_req = 1'b0;
    @(posedge clk); #1;
    check("t5_req_len", last_req_len, 8);

    // Reset asserted during a data access.
    mem_never = 1'b1;
    d_addr = 16'h0500; d_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6_req_before_rst", {31'd0, mem_req}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_req_async_drop", {30'd0, mem_req, busy}, 32'd0);
    @(posedge clk); #1;
    mem_never = 1'b0; mem_wait = 0; mem_key = 16'h1111;
    rst_n = 1'b1;
    check("t6_req_at_release", {31'd0, mem_req}, 32'd0);
    push_exp(1'b1, 16'h1411, 1'b0);
    @(posedge clk); #1;
    check("t6_restart", {15'd0, mem_req, mem_addr}, 32'h0001_0500);
    wait_ack("t6_ack", cyc);
    d_req = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
